// File: rtl/uart_rx_cfg_pkg.sv
// Shared types and helpers for the configurable UART receiver: parity modes,
// one-hot FSM states and the data-width clamp applied when a frame starts.
package uart_rx_cfg_pkg;

  localparam int DATA_BITS_MIN = 5;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_ODD   = 3'd1,
    PAR_EVEN  = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } par_mode_e;

  typedef enum logic [6:0] {
    ST_IDLE     = 7'b0000001,
    ST_START    = 7'b0000010,
    ST_DATA     = 7'b0000100,
    ST_PAR      = 7'b0001000,
    ST_STOP1    = 7'b0010000,
    ST_STOP2    = 7'b0100000,
    ST_BRK_WAIT = 7'b1000000
  } state_e;

  function automatic logic [3:0] clamp_bits(input logic [3:0] req, input int max_bits);
    if (int'(req) < DATA_BITS_MIN) return 4'(DATA_BITS_MIN);
    if (int'(req) > max_bits) return 4'(max_bits);
    return req;
  endfunction

  // Encodings 5..7 are reserved and behave as "no parity".
  function automatic par_mode_e decode_par(input logic [2:0] mode);
    return (mode > 3'd4) ? PAR_NONE : par_mode_e'(mode);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receive-word port of the UART: held word, its error flags and the consumer's ready.
// Handshake: a word transfers on any clk where rx_valid & rx_ready; rx_valid and the word stay stable until then.
interface uart_rx_cfg_if #(parameter int DATA_BITS_MAX = 9);
  logic [DATA_BITS_MAX-1:0] rx_data;
  logic                     rx_valid;
  logic                     rx_ready;
  logic                     par_err;
  logic                     frm_err;
  logic                     brk_det;
  logic                     ovr_err;

  modport master (output rx_data, rx_valid, par_err, frm_err, brk_det, ovr_err, input rx_ready);
  modport slave  (input rx_data, rx_valid, par_err, frm_err, brk_det, ovr_err, output rx_ready);
endinterface

// File: rtl/uart_rx_cfg_sampler.sv
// Line front end: synchroniser chain, 3-tap majority vote clocked by bd_tick,
// and a per-clk falling-edge pulse on the synchronised line.
module uart_rx_cfg_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic bd_tick,
  input  logic rx,
  output logic bit_s,
  output logic fall_s
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic [2:0]             vote_q;
  logic                   line_s;

  assign line_s = sync_q[SYNC_STAGES-1];

  // Everything presets to 1 so reset looks like an idle line and produces no edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= '1;
      sync_prev_q <= 1'b1;
      vote_q      <= 3'b111;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], rx};
      sync_prev_q <= line_s;
      if (bd_tick) vote_q <= {vote_q[1:0], line_s};
    end
  end

  assign bit_s  = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) | (vote_q[1] & vote_q[2]);
  assign fall_s = sync_prev_q & ~line_s;
endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with per-frame configuration latched at the start edge, parity and
// break checking, and a single-entry valid/ready output register with overrun flag.
module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int DATA_BITS_MAX = 9,
  parameter int OVS           = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bd_tick,
  input  logic                 rx_enable,
  input  logic                 rx,
  input  logic [3:0]           data_bits,
  input  logic                 stop2,
  input  logic [2:0]           par_mode,
  uart_rx_cfg_if.master        rx_if,
  output logic                 is_active,
  output state_e               dbg_state
);
  localparam int TW = $clog2(OVS);

  logic bit_s, fall_s;

  uart_rx_cfg_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .clk    (clk),
    .rst    (rst),
    .bd_tick(bd_tick),
    .rx     (rx),
    .bit_s  (bit_s),
    .fall_s (fall_s)
  );

  state_e                   state_q, state_d;
  logic [TW-1:0]            tick_q, tick_d;
  logic [3:0]               bit_q, bit_d, nbits_q, nbits_d;
  logic                     stop2_q, stop2_d;
  par_mode_e                par_q, par_d;
  logic [DATA_BITS_MAX-1:0] shreg_q, shreg_d;
  logic                     pacc_q, pacc_d, zero_q, zero_d;
  logic                     perr_q, perr_d, ferr_q, ferr_d;
  logic                     mid, frame_end, in_bit;

  logic [DATA_BITS_MAX-1:0] data_q;
  logic                     valid_q, operr_q, oferr_q, obrk_q, ovr_q;

  assign mid    = bd_tick && (tick_q == TW'(OVS - 1));
  assign in_bit = (state_q == ST_DATA) || (state_q == ST_PAR) ||
                  (state_q == ST_STOP1) || (state_q == ST_STOP2);

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    nbits_d   = nbits_q;
    stop2_d   = stop2_q;
    par_d     = par_q;
    shreg_d   = shreg_q;
    pacc_d    = pacc_q;
    zero_d    = zero_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    frame_end = 1'b0;

    if (in_bit && bd_tick) tick_d = mid ? '0 : tick_q + 1'b1;

    if (state_q != ST_IDLE && !rx_enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (rx_enable && fall_s) begin
          state_d = ST_START;
          tick_d  = '0;
          nbits_d = clamp_bits(data_bits, DATA_BITS_MAX);
          stop2_d = stop2;
          par_d   = decode_par(par_mode);
        end
        ST_START: if (bd_tick) begin
          if (tick_q == TW'(OVS/2 - 1)) begin
            tick_d = '0;
            if (bit_s) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
              bit_d   = '0;
              shreg_d = '0;
              pacc_d  = 1'b0;
              zero_d  = 1'b1;
              perr_d  = 1'b0;
              ferr_d  = 1'b0;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        ST_DATA: if (mid) begin
          for (int i = 0; i < DATA_BITS_MAX; i++)
            if (bit_q == 4'(i)) shreg_d[i] = bit_s;
          pacc_d = pacc_q ^ bit_s;
          zero_d = zero_q & ~bit_s;
          bit_d  = bit_q + 4'd1;
          if (bit_q + 4'd1 == nbits_q) state_d = (par_q == PAR_NONE) ? ST_STOP1 : ST_PAR;
        end
        ST_PAR: if (mid) begin
          zero_d = zero_q & ~bit_s;
          case (par_q)
            PAR_ODD:   perr_d = ~(pacc_q ^ bit_s);
            PAR_EVEN:  perr_d = pacc_q ^ bit_s;
            PAR_MARK:  perr_d = ~bit_s;
            PAR_SPACE: perr_d = bit_s;
            default:   perr_d = 1'b0;
          endcase
          state_d = ST_STOP1;
        end
        ST_STOP1: if (mid) begin
          zero_d = zero_q & ~bit_s;
          ferr_d = ~bit_s;
          if (stop2_q) state_d = ST_STOP2;
          else         frame_end = 1'b1;
        end
        ST_STOP2: if (mid) begin
          ferr_d    = ferr_q | ~bit_s;
          frame_end = 1'b1;
        end
        ST_BRK_WAIT: if (bd_tick && bit_s) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    // Leaving at mid-stop lets the next start edge be seen as soon as it arrives.
    if (frame_end) state_d = zero_d ? ST_BRK_WAIT : ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      nbits_q <= '0;
      stop2_q <= 1'b0;
      par_q   <= PAR_NONE;
      shreg_q <= '0;
      pacc_q  <= 1'b0;
      zero_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      nbits_q <= nbits_d;
      stop2_q <= stop2_d;
      par_q   <= par_d;
      shreg_q <= shreg_d;
      pacc_q  <= pacc_d;
      zero_q  <= zero_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // A frame ending while the previous word is still held is dropped and only flagged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      operr_q <= 1'b0;
      oferr_q <= 1'b0;
      obrk_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (frame_end) begin
      if (!valid_q || rx_if.rx_ready) begin
        data_q  <= zero_d ? '0 : shreg_q;
        valid_q <= 1'b1;
        operr_q <= perr_q;
        oferr_q <= ferr_d | zero_d;
        obrk_q  <= zero_d;
        ovr_q   <= 1'b0;
      end else begin
        ovr_q <= 1'b1;
      end
    end else if (valid_q && rx_if.rx_ready) begin
      valid_q <= 1'b0;
      operr_q <= 1'b0;
      oferr_q <= 1'b0;
      obrk_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign rx_if.rx_data  = data_q;
  assign rx_if.rx_valid = valid_q;
  assign rx_if.par_err  = operr_q;
  assign rx_if.frm_err  = oferr_q;
  assign rx_if.brk_det  = obrk_q;
  assign rx_if.ovr_err  = ovr_q;
  assign is_active      = in_bit || (state_q == ST_START);
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: serial frames driven bit by bit, accepted words
// collected from the handshake and compared against hand-computed values.
module tb_uart_rx_cfg;
  import uart_rx_cfg_pkg::*;

  localparam int DBM      = 9;
  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bd_tick = 1'b0;
  logic       rx_enable = 1'b0;
  logic       rx = 1'b1;
  logic       stop2 = 1'b0;
  logic [3:0] data_bits = 4'd8;
  logic [2:0] par_mode = 3'd0;
  logic       is_active;
  state_e     dbg_state;
  int         checks = 0;
  int         errors = 0;
  int         tick_div = 0;

  typedef struct packed {
    logic [DBM-1:0] data;
    logic           perr;
    logic           ferr;
    logic           brk;
    logic           ovr;
  } cap_t;
  cap_t cap_q[$];

  uart_rx_cfg_if #(.DATA_BITS_MAX(DBM)) rx_if ();

  uart_rx_cfg #(.DATA_BITS_MAX(DBM), .OVS(16), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .bd_tick  (bd_tick),
    .rx_enable(rx_enable),
    .rx       (rx),
    .data_bits(data_bits),
    .stop2    (stop2),
    .par_mode (par_mode),
    .rx_if    (rx_if.master),
    .is_active(is_active),
    .dbg_state(dbg_state)
  );

  // Clock / reset / baud tick
  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    tick_div = (tick_div + 1) % 4;
    bd_tick  = (tick_div == 0);
  end

  // Handshake monitor: records every accepted word
  initial forever begin
    @(negedge clk);
    #1;
    if (rx_if.rx_valid && rx_if.rx_ready)
      cap_q.push_back({rx_if.rx_data, rx_if.par_err, rx_if.frm_err, rx_if.brk_det, rx_if.ovr_err});
  end

  // Driver tasks
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [8:0] d, input int nbits, input int pbit, input int nstop);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(d[i]);
    if (pbit >= 0) drive_bit(pbit[0]);
    for (int i = 0; i < nstop; i++) drive_bit(1'b1);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", rx_if.rx_valid); end
    checks++; if (rx_if.rx_data !== 9'h000) begin errors++; $display("FAIL reset_data: got %0h exp 0", rx_if.rx_data); end
    checks++; if ({rx_if.par_err, rx_if.frm_err, rx_if.brk_det, rx_if.ovr_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b exp 0000", {rx_if.par_err, rx_if.frm_err, rx_if.brk_det, rx_if.ovr_err}); end
    checks++; if (is_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b exp 0", is_active); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %b exp %b", dbg_state, ST_IDLE); end
    rst = 1'b1;
    rx_enable = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b exp 0", rx_if.rx_valid); end
  endtask

  task automatic test_8n1();
    cap_t c;
    cap_q.delete();
    data_bits = 4'd8; stop2 = 1'b0; par_mode = 3'd0;
    send_frame(9'h0A5, 8, -1, 1);
    drive_bit(1'b1);
    checks++; if (cap_q.size() != 1) begin errors++; $display("FAIL 8n1_count: got %0d exp 1", cap_q.size()); end
    if (cap_q.size() > 0) begin
      c = cap_q[0];
      checks++; if (c.data !== 9'h0A5) begin errors++; $display("FAIL 8n1_data: got %0h exp 0a5", c.data); end
      checks++; if ({c.perr, c.ferr, c.brk, c.ovr} !== 4'b0000) begin
        errors++; $display("FAIL 8n1_flags: got %b exp 0000", {c.perr, c.ferr, c.brk, c.ovr}); end
    end
    checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL 8n1_valid_drop: got %b exp 0", rx_if.rx_valid); end
    checks++; if (is_active !== 1'b0) begin errors++; $display("FAIL 8n1_active: got %b exp 0", is_active); end
  endtask

  task automatic test_7e2_parity();
    cap_t c;
    logic [8:0] d;
    d = 9'h035;
    cap_q.delete();
    data_bits = 4'd7; stop2 = 1'b1; par_mode = 3'd2;
    drive_bit(1'b0);
    // Config moves mid-frame; the latched 7E2 must still apply.
    data_bits = 4'd8; stop2 = 1'b0; par_mode = 3'd0;
    for (int i = 0; i < 7; i++) drive_bit(d[i]);
    drive_bit(1'b1);
    drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b1);
    checks++; if (cap_q.size() != 1) begin errors++; $display("FAIL 7e2_count: got %0d exp 1", cap_q.size()); end
    if (cap_q.size() > 0) begin
      c = cap_q[0];
      checks++; if (c.data !== 9'h035) begin errors++; $display("FAIL 7e2_data: got %0h exp 035", c.data); end
      checks++; if (c.perr !== 1'b1) begin errors++; $display("FAIL 7e2_perr: got %b exp 1", c.perr); end
      checks++; if (c.ferr !== 1'b0) begin errors++; $display("FAIL 7e2_ferr: got %b exp 0", c.ferr); end
    end
  endtask

  task automatic test_clamp_parity();
    cap_t c;
    cap_q.delete();
    stop2 = 1'b0;
    data_bits = 4'd2;  par_mode = 3'd7;
    send_frame(9'h015, 5, -1, 1);
    data_bits = 4'd15; par_mode = 3'd1;
    send_frame(9'h1A5, 9, 0, 1);
    data_bits = 4'd5;  par_mode = 3'd3;
    send_frame(9'h00A, 5, 0, 1);
    drive_bit(1'b1);
    checks++; if (cap_q.size() != 3) begin errors++; $display("FAIL clamp_count: got %0d exp 3", cap_q.size()); end
    if (cap_q.size() == 3) begin
      c = cap_q[0];
      checks++; if ({c.data, c.perr} !== {9'h015, 1'b0}) begin errors++; $display("FAIL clamp_min: got %0h/%b exp 015/0", c.data, c.perr); end
      c = cap_q[1];
      checks++; if ({c.data, c.perr} !== {9'h1A5, 1'b0}) begin errors++; $display("FAIL clamp_max_odd: got %0h/%b exp 1a5/0", c.data, c.perr); end
      c = cap_q[2];
      checks++; if ({c.data, c.perr} !== {9'h00A, 1'b1}) begin errors++; $display("FAIL mark_err: got %0h/%b exp 00a/1", c.data, c.perr); end
    end
    data_bits = 4'd8; par_mode = 3'd0;
  endtask

  task automatic test_false_start();
    cap_q.delete();
    rx = 1'b0;
    repeat (16) @(negedge clk);
    checks++; if (is_active !== 1'b1) begin errors++; $display("FAIL fs_active_on: got %b exp 1", is_active); end
    rx = 1'b1;
    repeat (24) @(negedge clk);
    checks++; if (is_active !== 1'b0) begin errors++; $display("FAIL fs_active_off: got %b exp 0", is_active); end
    repeat (2 * BIT_CLKS) @(negedge clk);
    checks++; if (cap_q.size() != 0 || rx_if.rx_valid !== 1'b0) begin
      errors++; $display("FAIL fs_no_word: got %0d words valid %b exp 0 words", cap_q.size(), rx_if.rx_valid); end
  endtask

  task automatic test_break();
    cap_t c;
    cap_q.delete();
    data_bits = 4'd8; stop2 = 1'b0; par_mode = 3'd0;
    rx = 1'b0;
    repeat (11 * BIT_CLKS) @(negedge clk);
    checks++; if (dbg_state !== ST_BRK_WAIT) begin errors++; $display("FAIL brk_state: got %b exp %b", dbg_state, ST_BRK_WAIT); end
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    checks++; if (cap_q.size() != 1) begin errors++; $display("FAIL brk_count: got %0d exp 1", cap_q.size()); end
    if (cap_q.size() > 0) begin
      c = cap_q[0];
      checks++; if (c.data !== 9'h000) begin errors++; $display("FAIL brk_data: got %0h exp 0", c.data); end
      checks++; if ({c.brk, c.ferr, c.perr, c.ovr} !== 4'b1100) begin
        errors++; $display("FAIL brk_flags: got %b exp 1100", {c.brk, c.ferr, c.perr, c.ovr}); end
    end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL brk_release: got %b exp %b", dbg_state, ST_IDLE); end
  endtask

  task automatic test_overrun();
    cap_t c;
    cap_q.delete();
    rx_if.rx_ready = 1'b0;
    send_frame(9'h011, 8, -1, 1);
    send_frame(9'h022, 8, -1, 1);
    drive_bit(1'b1);
    checks++; if (rx_if.rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b exp 1", rx_if.rx_valid); end
    checks++; if (rx_if.rx_data !== 9'h011) begin errors++; $display("FAIL ovr_data: got %0h exp 011", rx_if.rx_data); end
    checks++; if (rx_if.ovr_err !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b exp 1", rx_if.ovr_err); end
    checks++; if ({rx_if.par_err, rx_if.frm_err} !== 2'b00) begin
      errors++; $display("FAIL ovr_other: got %b exp 00", {rx_if.par_err, rx_if.frm_err}); end
    rx_if.rx_ready = 1'b1;
    @(negedge clk);
    rx_if.rx_ready = 1'b0;
    @(negedge clk);
    checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_pop_valid: got %b exp 0", rx_if.rx_valid); end
    checks++; if (rx_if.ovr_err !== 1'b0) begin errors++; $display("FAIL ovr_pop_flag: got %b exp 0", rx_if.ovr_err); end
    checks++; if (cap_q.size() != 1) begin errors++; $display("FAIL ovr_pop_count: got %0d exp 1", cap_q.size()); end
    if (cap_q.size() > 0) begin
      c = cap_q[0];
      checks++; if ({c.data, c.ovr} !== {9'h011, 1'b1}) begin errors++; $display("FAIL ovr_pop_word: got %0h/%b exp 011/1", c.data, c.ovr); end
    end
    rx_if.rx_ready = 1'b1;
  endtask

  task automatic test_abort_reset();
    cap_t c;
    cap_q.delete();
    data_bits = 4'd8; stop2 = 1'b0; par_mode = 3'd0;
    drive_bit(1'b0);
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
    rx = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    rx_enable = 1'b0;
    @(negedge clk);
    checks++; if (is_active !== 1'b0) begin errors++; $display("FAIL abort_active: got %b exp 0", is_active); end
    repeat (6 * BIT_CLKS) @(negedge clk);
    rx_enable = 1'b1;
    drive_bit(1'b0);
    rx = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (is_active !== 1'b0) begin errors++; $display("FAIL rst_active: got %b exp 0", is_active); end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    checks++; if (cap_q.size() != 0 || rx_if.rx_valid !== 1'b0) begin
      errors++; $display("FAIL abort_no_word: got %0d words valid %b exp 0 words", cap_q.size(), rx_if.rx_valid); end
    send_frame(9'h05A, 8, -1, 1);
    drive_bit(1'b1);
    checks++; if (cap_q.size() != 1) begin errors++; $display("FAIL clean_count: got %0d exp 1", cap_q.size()); end
    if (cap_q.size() > 0) begin
      c = cap_q[0];
      checks++; if (c.data !== 9'h05A) begin errors++; $display("FAIL clean_data: got %0h exp 05a", c.data); end
      checks++; if ({c.perr, c.ferr, c.brk, c.ovr} !== 4'b0000) begin
        errors++; $display("FAIL clean_flags: got %b exp 0000", {c.perr, c.ferr, c.brk, c.ovr}); end
    end
  endtask

  // Sequence and final report
  initial begin
    rx_if.rx_ready = 1'b1;
    test_reset();
    test_8n1();
    test_7e2_parity();
    test_clamp_parity();
    test_false_start();
    test_break();
    test_overrun();
    test_abort_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
